serial_subtractor8: RTL and testbench

SERIAL_SUBTRACTOR8 -- requirements
Module: serial_subtractor8

---
 rtl/serial_subtractor8.sv | 93 +++++++++
 tb/tb_serial_subtractor8.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor8.sv
// Bit-serial 8-bit subtractor: d = a - b - bin over eight LSB-first cycles.
// d and bout are updated only when a result completes and hold until the next one.
//
// state | meaning
// IDLE  | waiting for start; d/bout hold the last result
// RUN   | one bit per cycle, cnt 0..7
// DONE  | d/bout just became valid; done pulses; start here chains a new operation

module serial_subtractor8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic [7:0] d,
    output logic       bout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] sh_a, sh_b, res;
    logic       br;
    logic [2:0] cnt;
    logic       accept;
    logic       bit_diff;
    logic       br_nxt;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign bit_diff = sh_a[0] ^ sh_b[0] ^ br;
    assign br_nxt   = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // res is a private accumulator so d never shows a partially built difference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a <= 8'h00;
            sh_b <= 8'h00;
            res  <= 8'h00;
            br   <= 1'b0;
            cnt  <= 3'd0;
            d    <= 8'h00;
            bout <= 1'b0;
        end else if (accept) begin
            sh_a <= a;
            sh_b <= b;
            br   <= bin;
            res  <= 8'h00;
            cnt  <= 3'd0;
        end else if (state == RUN) begin
            sh_a <= {1'b0, sh_a[7:1]};
            sh_b <= {1'b0, sh_b[7:1]};
            res  <= {bit_diff, res[7:1]};
            br   <= br_nxt;
            cnt  <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                d    <= {bit_diff, res[7:1]};
                bout <= br_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Scoreboard bench for serial_subtractor8: expected results are queued when
// start is driven and compared whenever done is seen.

module tb_serial_subtractor8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] d;
    logic       bout, busy, done;

    logic [8:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_err  = 0;
    int         n_push = 0;
    int         n_done = 0;
    logic       prev_done = 1'b0;

    serial_subtractor8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // reference: 9-bit wide difference; bit 8 is set exactly when a < b + bin
    function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        logic [8:0] r;
        r = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (prev_done) check("done_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("d", {24'd0, d}, {24'd0, e[7:0]});
                check("bout", {31'd0, bout}, {31'd0, e[8]});
            end
        end
        prev_done = done && !rst;
    end

    task automatic drive_start(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        exp_q.push_back(model(ta, tb_v, tbin));
        n_push++;
    endtask

    task automatic wait_done(input string tag, input int want_k, inout int k);
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(tag, k, want_k);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
        int k;
        int nbusy;
        @(negedge clk);
        drive_start(ta, tb_v, tbin);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
        k     = 1;
        nbusy = busy ? 1 : 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (busy) nbusy++;
        end
        check("latency", k, 9);
        check("busy_cycles", nbusy, 8);
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bin   = 1'b0;
        #3;
        check("rst_d", {24'd0, d}, 32'd0);
        check("rst_bout", {31'd0, bout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'd5, 8'd3, 1'b0);
        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'd0, 8'd0, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);

        // start pulse during RUN cycle 4 must be ignored
        @(negedge clk);
        drive_start(8'd20, 8'd13, 1'b0);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 5) begin
            @(negedge clk);
            k++;
        end
        a = 8'd1; b = 8'd0; start = 1'b1;
        @(negedge clk);
        k++;
        start = 1'b0;
        wait_done("mid_start_latency", 9, k);
        repeat (4) @(negedge clk);
        check("mid_start_idle_busy", {31'd0, busy}, 32'd0);

        // reset mid-RUN aborts the operation (nothing queued for it)
        @(negedge clk);
        a = 8'd100; b = 8'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 4) begin
            @(negedge clk);
            k++;
        end
        #2 rst = 1'b1;
        #1;
        check("abort_d", {24'd0, d}, 32'd0);
        check("abort_bout", {31'd0, bout}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", {31'd0, done}, 32'd0);
        run_op(8'd2, 8'd3, 1'b1);

        // back-to-back: start held through DONE
        @(negedge clk);
        drive_start(8'd200, 8'd55, 1'b1);
        @(negedge clk);
        k = 1;
        drive_start(8'd17, 8'd99, 1'b0);
        while (k < 9) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done1", {31'd0, done}, 32'd1);
        @(negedge clk);
        k++;
        check("b2b_no_idle", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done("b2b_latency2", 18, k);

        for (int i = 0; i < 10; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("done_count", n_done, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
